// File: rtl/trace_pkg.sv
// Shared types and record layout for the retirement trace recorder.
// A record is {pc, inst, we, waddr, wdata}, drained as four 32-bit words.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int REC_W     = 102;
  localparam int WDATA_LSB = 0;
  localparam int WADDR_LSB = 32;
  localparam int WE_LSB    = 37;
  localparam int INST_LSB  = 38;
  localparam int PC_LSB    = 70;

  localparam logic [1:0] W_PC   = 2'd0;
  localparam logic [1:0] W_INST = 2'd1;
  localparam logic [1:0] W_WB   = 2'd2;
  localparam logic [1:0] W_DATA = 2'd3;

  function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] pc,
                                                input logic [31:0] inst,
                                                input logic        we,
                                                input logic [4:0]  waddr,
                                                input logic [31:0] wdata);
    return {pc, inst, we, waddr, wdata};
  endfunction

  function automatic logic [31:0] rec_word(input logic [REC_W-1:0] rec,
                                           input logic [1:0]       sel);
    logic [31:0] w;
    case (sel)
      W_PC:    w = rec[PC_LSB +: 32];
      W_INST:  w = rec[INST_LSB +: 32];
      W_WB:    w = {rec[WE_LSB], 26'b0, rec[WADDR_LSB +: 5]};
      default: w = rec[WDATA_LSB +: 32];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module trace_ram
  import trace_pkg::*;
#(
  parameter int  DEPTH = 1024,
  parameter int  WIDTH = REC_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
    if (re) rdata <= mem_reg[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retirement trace recorder: trigger, circular capture into trace_ram, then
// an oldest-first drain of four words per record over a valid/ready stream.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 1024,
  parameter int  MAX_CNT = 1100,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          mode,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic          stop,
  input  logic          c_valid,
  input  logic [31:0]   c_pc,
  input  logic [31:0]   c_inst,
  input  logic          c_we,
  input  logic [4:0]    c_waddr,
  input  logic [31:0]   c_wdata,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [31:0]   MAX_W = 32'(MAX_CNT);

  state_t             state_reg, state_next;
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               ovf_reg, ovf_next;
  logic [31:0]        total_reg, total_next;
  logic [CW-1:0]      fetch_rem_reg, fetch_rem_next;
  logic [CW-1:0]      load_rem_reg, load_rem_next;
  logic               q_valid_reg, q_valid_next;
  logic [REC_W-1:0]   rec_reg, rec_next;
  logic [1:0]         word_idx_reg, word_idx_next;
  logic               out_valid_reg, out_valid_next;
  logic               last_rec_reg, last_rec_next;
  logic               done_reg, done_next;

  logic               ram_we, ram_re;
  logic [REC_W-1:0]   ram_q;
  logic               trig_hit, capture_end, xfer, word_end, load;
  logic [31:0]        word_arr [4];

  trace_ram #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (pack_rec(c_pc, c_inst, c_we, c_waddr, c_wdata)),
    .re    (ram_re),
    .raddr (rd_ptr_reg),
    .rdata (ram_q)
  );

  assign trig_hit    = c_valid && (!trig_en || (c_pc == trig_pc));
  assign capture_end = ((MAX_CNT != 0) && (total_reg + 32'd1 == MAX_W)) ||
                       (!mode && (count_reg + 1'b1 == FULL));
  assign xfer        = out_valid_reg && rd_ready;
  assign word_end    = xfer && (word_idx_reg == W_DATA);
  // ram_q is a one-deep prefetch stage; it refills the same cycle it is consumed.
  assign load        = (state_reg == ST_DRAIN) && q_valid_reg && (!out_valid_reg || word_end);
  assign ram_re      = (state_reg == ST_DRAIN) && (fetch_rem_reg != '0) && (!q_valid_reg || load);

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    total_next     = total_reg;
    fetch_rem_next = fetch_rem_reg;
    load_rem_next  = load_rem_reg;
    q_valid_next   = q_valid_reg;
    rec_next       = rec_reg;
    word_idx_next  = word_idx_reg;
    out_valid_next = out_valid_reg;
    last_rec_next  = last_rec_reg;
    done_next      = 1'b0;
    ram_we         = 1'b0;

    if (arm) begin
      state_next     = ST_ARMED;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      ovf_next       = 1'b0;
      total_next     = '0;
      fetch_rem_next = '0;
      load_rem_next  = '0;
      q_valid_next   = 1'b0;
      word_idx_next  = '0;
      out_valid_next = 1'b0;
      last_rec_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_ARMED: begin
          if (stop) begin
            state_next = ST_DRAIN;
          end else if (trig_hit) begin
            ram_we     = 1'b1;
            state_next = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          ram_we = c_valid;
          if (stop) state_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (ram_re) begin
            rd_ptr_next    = rd_ptr_reg + 1'b1;
            fetch_rem_next = fetch_rem_reg - 1'b1;
          end
          q_valid_next = ram_re ? 1'b1 : (load ? 1'b0 : q_valid_reg);
          if (load) begin
            rec_next       = ram_q;
            word_idx_next  = W_PC;
            out_valid_next = 1'b1;
            last_rec_next  = (load_rem_reg == CW'(1));
            load_rem_next  = load_rem_reg - 1'b1;
          end else if (word_end) begin
            out_valid_next = 1'b0;
            if (last_rec_reg) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else if (xfer) begin
            word_idx_next = word_idx_reg + 2'd1;
          end
          // Nothing was captured: finish without ever raising rd_valid.
          if (load_rem_reg == '0 && !out_valid_reg) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: ;
      endcase

      if (ram_we) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        total_next  = total_reg + 32'd1;
        if (count_reg == FULL) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
          ovf_next    = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
        if (capture_end) state_next = ST_DRAIN;
      end

      if (state_reg != ST_DRAIN && state_next == ST_DRAIN) begin
        fetch_rem_next = count_next;
        load_rem_next  = count_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      total_reg     <= '0;
      fetch_rem_reg <= '0;
      load_rem_reg  <= '0;
      q_valid_reg   <= 1'b0;
      rec_reg       <= '0;
      word_idx_reg  <= '0;
      out_valid_reg <= 1'b0;
      last_rec_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      total_reg     <= total_next;
      fetch_rem_reg <= fetch_rem_next;
      load_rem_reg  <= load_rem_next;
      q_valid_reg   <= q_valid_next;
      rec_reg       <= rec_next;
      word_idx_reg  <= word_idx_next;
      out_valid_reg <= out_valid_next;
      last_rec_reg  <= last_rec_next;
      done_reg      <= done_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign word_arr[gi] = rec_word(rec_reg, 2'(gi));
  end

  assign rd_valid = out_valid_reg;
  assign rd_data  = word_arr[word_idx_reg];
  assign rd_last  = out_valid_reg && last_rec_reg && (word_idx_reg == W_DATA);
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign count    = count_reg;
  assign overflow = ovf_reg;

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable on-chip retirement trace recorder for the single-cycle MIPS cores (CPU31/CPU54). Each cycle it taps the core's retire port (pc, instruction, register-file write). It stores records in a parametrised circular BRAM buffer, with PC-match trigger, record-count limit and stop-when-full or wrap-around modes. After capture it drains records oldest-first as 32-bit words over a valid/ready stream, which the board-level UART/debug path consumes.

## Interface
- DEPTH, 1024: record slots; power of two, ≥ 4
- MAX_CNT, 1100: records to capture after trigger; 0 = unlimited
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle pulse: clear buffer, enter ARMED
- mode  in  1  0 = stop when full, 1 = circular (keep most recent DEPTH)
- trig_en  in  1  1 = wait for trig_pc, 0 = start on first retire after arm
- trig_pc  in  32  trigger PC
- stop  in  1  pulse: end capture
- c_valid  in  1  instruction retired this cycle
- c_pc, c_inst  in  32 each  retired PC / instruction word
- c_we  in  1;  c_waddr  in  5;  c_wdata  in  32  register write of that instruction
- rd_valid  out  1;  rd_data  out  32;  rd_last  out  1;  rd_ready  in  1  drain stream
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when drain completes
- count  out  $clog2(DEPTH)+1  records held (saturates at DEPTH)
- overflow  out  1  buffer wrapped (mode 1 only)

## Operation
- States: IDLE → (arm) ARMED → (trigger) CAPTURE → (end) DRAIN → IDLE.
- ARMED: if trig_en = 0, the first c_valid triggers. Otherwise the trigger is c_valid && c_pc == trig_pc. The triggering record is captured (inclusive).
- CAPTURE: each c_valid writes record {c_pc, c_inst, c_we, c_waddr, c_wdata} at wr_ptr, then wr_ptr++ mod DEPTH. Captured-total counter increments.
- End of capture is any of:
  - captured total reaches MAX_CNT (MAX_CNT ≠ 0);
  - stop = 1;
  - mode 0 and count reaches DEPTH.
- mode 1 full: overwrite oldest. rd_ptr advances with wr_ptr. count stays DEPTH; overflow sets.
- stop in ARMED ends with zero records. DRAIN then immediately returns to IDLE and pulses done. rd_valid never rises.
- DRAIN: records go out oldest-first, 4 words each:
  - word 0 = pc
  - word 1 = inst
  - word 2 = {c_we, 26'b0, c_waddr}
  - word 3 = wdata
- A word transfers when rd_valid && rd_ready. rd_last = 1 on word 3 of the final record. The transfer of rd_last returns the block to IDLE and pulses done.
- arm in any non-IDLE state aborts and restarts: pointers, count and overflow clear, then ARMED.
- arm has priority over stop; stop has priority over trigger in the same cycle.
- Reset: state IDLE, pointers 0. All outputs 0: rd_valid, rd_data, rd_last, busy, done, count, overflow.

## Timing
- A record is written on the rising edge where c_valid = 1 in CAPTURE, or where the trigger fires in ARMED. count reflects it on the next cycle.
- The edge that writes the terminating record (MAX_CNT-th, or DEPTH-th in mode 0) also moves the block to DRAIN. stop together with c_valid: that record is captured, then DRAIN.
- RAM read is synchronous (1 cycle). rd_valid first rises ≤ 2 cycles after entering DRAIN.
- Sustained throughput is 1 word/cycle while rd_ready = 1.
- rd_data and rd_last hold stable while rd_valid && !rd_ready. rd_valid never drops without a transfer, except on arm or rst.
- c_valid is ignored in IDLE and DRAIN.

## Structure
- trace_pkg holds:
  - state encoding (IDLE, ARMED, CAPTURE, DRAIN);
  - record field widths and offsets (REC_W = 102);
  - word-select constants (W_PC, W_INST, W_WB, W_DATA).
- Sub-module trace_ram: simple dual-port RAM, DEPTH × REC_W, sync write, sync read, BRAM-inferable.
- Top-level holds the FSM, pointers, counters, trigger compare and the word serializer with output skid register.

## Test plan
- trig_en = 0, mode 0, MAX_CNT = 1100, DEPTH = 1024, retire every cycle from pc 0x00400000: capture ends at 1024 records. Drain gives 4096 words; first two are 0x00400000 then 0x3c1d1001; rd_last on word 4096; done pulses.
- trig_en = 1, trig_pc = 0x00400010, retires pc 0x00400000+4k: first drained pc is 0x00400010. MAX_CNT = 8 → exactly 8 records, count = 8.
- mode 1, DEPTH = 16, MAX_CNT = 40: overflow = 1, count = 16. First drained pc is that of retire #25 (oldest kept).
- Random rd_ready (50 %): every word drains exactly once in order; rd_data is stable across stalls.
- stop in ARMED → zero records, no rd_valid, done pulse. arm mid-DRAIN → rd_valid drops within 1 cycle; state ARMED, count 0.
- rst asserted mid-CAPTURE (async, between edges): all outputs 0 immediately; IDLE after release.
